// File: rtl/phase_pkg.sv
// Shared phase constants, FSM state type and phase decode helper.
// Used by phase_gen; the optional PHASE_GEN_STEP_EN build lives in phase_gen.
package phase_pkg;

    localparam int PHASE_W = 5;
    localparam int F_IDX   = 0;
    localparam int R_IDX   = 1;
    localparam int X_IDX   = 2;
    localparam int M_IDX   = 3;
    localparam int W_IDX   = 4;

    typedef enum logic [2:0] {
        FWAIT,
        F,
        R,
        X,
        M,
        W,
        HALT,
        FAULT
    } state_t;

    function automatic logic [PHASE_W-1:0] phase_of(input state_t s);
        logic [PHASE_W-1:0] p;
        p = '0;
        case (s)
            F:       p[F_IDX] = 1'b1;
            R:       p[R_IDX] = 1'b1;
            X:       p[X_IDX] = 1'b1;
            M:       p[M_IDX] = 1'b1;
            W:       p[W_IDX] = 1'b1;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/phase_gen_wait_timer.sv
// Handshake wait counter shared by the fetch and data-access waits.
// Ports: clk, rst, clear (entry to a wait), tick (waiting), done (ack), expired.
module wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    input  logic done,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (tick && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

    // An ack on the last allowed cycle suppresses expiry.
    assign expired = (TIMEOUT > 0) && tick && !done && (cnt == LAST);

endmodule

// File: rtl/phase_gen.sv
// Five-phase instruction sequencer with fetch/data handshakes and timeout.
// Ports: clk, rst, phase, imem_req/ack, dmem_req/ack, mem_op, halt_in, run,
// halted, fault, instr_count; step_mode/step when PHASE_GEN_STEP_EN is defined.
module phase_gen
    import phase_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PHASE_W-1:0] phase,
    output logic               imem_req,
    input  logic               imem_ack,
    output logic               dmem_req,
    input  logic               dmem_ack,
    input  logic               mem_op,
    input  logic               halt_in,
    input  logic               run,
`ifdef PHASE_GEN_STEP_EN
    input  logic               step_mode,
    input  logic               step,
`endif
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   instr_count
);

    state_t state;
    state_t state_n;
    logic   mem_op_q;
    logic   tick;
    logic   done;
    logic   clear;
    logic   expired;
    logic   go_halt;
    logic   wake;

`ifdef PHASE_GEN_STEP_EN
    assign go_halt = halt_in || step_mode;
    assign wake    = run || step;
`else
    assign go_halt = halt_in;
    assign wake    = run;
`endif

    // Acks only count while the matching request is up.
    assign tick = (state == FWAIT) || ((state == M) && mem_op_q);
    assign done = ((state == FWAIT) && imem_ack)
               || ((state == M) && mem_op_q && dmem_ack);

    assign clear = (state_n != state)
                && ((state_n == FWAIT) || (state_n == M));

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .tick   (tick),
        .done   (done),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FWAIT;
            mem_op_q    <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_n;
            if (state == X) begin
                mem_op_q <= mem_op;
            end
            if (state == W) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            FWAIT: begin
                if (imem_ack) begin
                    state_n = F;
                end else if (expired) begin
                    state_n = FAULT;
                end
            end
            F: state_n = R;
            R: state_n = X;
            X: state_n = M;
            M: begin
                if (!mem_op_q || dmem_ack) begin
                    state_n = W;
                end else if (expired) begin
                    state_n = FAULT;
                end
            end
            W:     state_n = go_halt ? HALT : FWAIT;
            HALT:  state_n = wake ? FWAIT : HALT;
            FAULT: state_n = FAULT;
            default: state_n = FWAIT;
        endcase
    end

    assign phase    = phase_of(state);
    assign imem_req = (state == FWAIT);
    assign dmem_req = (state == M) && mem_op_q;
    assign halted   = (state == HALT);
    assign fault    = (state == FAULT);

endmodule

// File: tb/tb_phase_gen.sv
// Self-checking bench for phase_gen: vector table, corner sequences, random.
// Two instances: A (TIMEOUT=4, CNT_W=4) and B (defaults).
module tb_phase_gen;

    logic clk;
    logic rst;
    logic imem_ack;
    logic dmem_ack;
    logic mem_op;
    logic halt_in;
    logic run;
    logic step_mode;
    logic step;

    logic [4:0]  a_phase, b_phase;
    logic        a_imem, b_imem, a_dmem, b_dmem;
    logic        a_halt, b_halt, a_fault, b_fault;
    logic [3:0]  a_cnt;
    logic [31:0] b_cnt;

    phase_gen #(.TIMEOUT(4), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .phase(a_phase),
        .imem_req(a_imem), .imem_ack(imem_ack),
        .dmem_req(a_dmem), .dmem_ack(dmem_ack),
        .mem_op(mem_op), .halt_in(halt_in), .run(run),
`ifdef PHASE_GEN_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .halted(a_halt), .fault(a_fault), .instr_count(a_cnt)
    );

    phase_gen u_b (
        .clk(clk), .rst(rst), .phase(b_phase),
        .imem_req(b_imem), .imem_ack(imem_ack),
        .dmem_req(b_dmem), .dmem_ack(dmem_ack),
        .mem_op(mem_op), .halt_in(halt_in), .run(run),
`ifdef PHASE_GEN_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .halted(b_halt), .fault(b_fault), .instr_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Sampled (negedge) copies of the outputs.
    logic [4:0]  sa_phase, sb_phase;
    logic        sa_imem, sb_imem, sa_dmem, sb_dmem;
    logic        sa_halt, sb_halt, sa_fault, sb_fault;
    logic [3:0]  sa_cnt;
    logic [31:0] sb_cnt;
    logic        prev_a0 = 1'b0;
    logic        prev_b0 = 1'b0;

    // Reference model: per instance, stage -1 = waiting for fetch.
    int              to_p[2]   = '{4, 255};
    int              cw_p[2]   = '{4, 32};
    int              m_stage[2];
    bit              m_halt[2];
    bit              m_fault[2];
    int              m_wait[2];
    bit              m_memop[2];
    longint unsigned m_cnt[2];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [40:0] exp_vec(input int k);
        logic [4:0] p;
        bit idle;
        idle = m_halt[k] || m_fault[k] || (m_stage[k] < 0);
        p = idle ? 5'd0 : (5'd1 << m_stage[k]);
        return {p, !m_halt[k] && !m_fault[k] && (m_stage[k] == -1),
                !idle && (m_stage[k] == 3) && m_memop[k],
                m_halt[k], m_fault[k], 32'(m_cnt[k])};
    endfunction

    task automatic model_step(input int k);
        bit wake;
        bit smode;
        bit out_of_time;
        wake  = run;
        smode = 1'b0;
`ifdef PHASE_GEN_STEP_EN
        wake  = run || step;
        smode = step_mode;
`endif
        out_of_time = (to_p[k] > 0) && (m_wait[k] == to_p[k] - 1);
        if (rst) begin
            m_stage[k] = -1;
            m_halt[k]  = 0;
            m_fault[k] = 0;
            m_wait[k]  = 0;
            m_memop[k] = 0;
            m_cnt[k]   = 0;
        end else if (m_fault[k]) begin
            m_fault[k] = 1;
        end else if (m_halt[k]) begin
            if (wake) begin
                m_halt[k]  = 0;
                m_stage[k] = -1;
                m_wait[k]  = 0;
            end
        end else begin
            case (m_stage[k])
                -1: begin
                    if (imem_ack) m_stage[k] = 0;
                    else if (out_of_time) m_fault[k] = 1;
                    else m_wait[k]++;
                end
                0, 1: m_stage[k]++;
                2: begin
                    m_memop[k] = mem_op;
                    m_stage[k] = 3;
                    m_wait[k]  = 0;
                end
                3: begin
                    if (!m_memop[k] || dmem_ack) m_stage[k] = 4;
                    else if (out_of_time) m_fault[k] = 1;
                    else m_wait[k]++;
                end
                default: begin
                    m_cnt[k] = (m_cnt[k] + 1) % (64'd1 << cw_p[k]);
                    if (halt_in || smode) begin
                        m_halt[k] = 1;
                    end else begin
                        m_stage[k] = -1;
                        m_wait[k]  = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        sa_phase = a_phase; sb_phase = b_phase;
        sa_imem  = a_imem;  sb_imem  = b_imem;
        sa_dmem  = a_dmem;  sb_dmem  = b_dmem;
        sa_halt  = a_halt;  sb_halt  = b_halt;
        sa_fault = a_fault; sb_fault = b_fault;
        sa_cnt   = a_cnt;   sb_cnt   = b_cnt;
        if (chk_en) begin
            chk("modelA", 64'({sa_phase, sa_imem, sa_dmem, sa_halt,
                sa_fault, 32'(sa_cnt)}), 64'(exp_vec(0)));
            chk("modelB", 64'({sb_phase, sb_imem, sb_dmem, sb_halt,
                sb_fault, sb_cnt}), 64'(exp_vec(1)));
            chk("ph0_twice_a", 64'(prev_a0 & sa_phase[0]), 64'd0);
            chk("ph0_twice_b", 64'(prev_b0 & sb_phase[0]), 64'd0);
            prev_a0 = sa_phase[0];
            prev_b0 = sb_phase[0];
        end
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic clr_in();
        imem_ack = 0; dmem_ack = 0; mem_op = 0;
        halt_in = 0; run = 0; step = 0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    // Starts in FWAIT; ack at once, optional data access acked at once.
    task automatic run_instr(input bit mop, input bit hlt);
        imem_ack = 1; cyc();
        imem_ack = 0; cyc();
        cyc();
        mem_op = mop; cyc();
        mem_op = 0;
        dmem_ack = mop; cyc();
        dmem_ack = 0;
        halt_in = hlt; cyc();
        halt_in = 0;
    endtask

    typedef struct {
        logic        iack;
        logic        mop;
        logic [4:0]  ph;
        logic        ireq;
        logic        dreq;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n8, nd, ni;
        tbl[0] = '{0, 0, 5'd0,  1, 0, 0};
        tbl[1] = '{0, 0, 5'd0,  1, 0, 0};
        tbl[2] = '{1, 0, 5'd0,  1, 0, 0};
        tbl[3] = '{0, 0, 5'd1,  0, 0, 0};
        tbl[4] = '{0, 0, 5'd2,  0, 0, 0};
        tbl[5] = '{0, 0, 5'd4,  0, 0, 0};
        tbl[6] = '{0, 0, 5'd8,  0, 0, 0};
        tbl[7] = '{0, 0, 5'd16, 0, 0, 0};
        tbl[8] = '{0, 0, 5'd0,  1, 0, 1};

        step_mode = 0;
        clr_in();
        rst = 1;
        cyc();
        chk_en = 1;
        rst = 0;

        // Basic instruction: table of inputs and expected outputs.
        for (int i = 0; i < 9; i++) begin
            imem_ack = tbl[i].iack;
            mem_op   = tbl[i].mop;
            cyc();
            chk($sformatf("tbl%0d_ph", i), 64'(sb_phase), 64'(tbl[i].ph));
            chk($sformatf("tbl%0d_ireq", i), 64'(sb_imem),
                64'(tbl[i].ireq));
            chk($sformatf("tbl%0d_dreq", i), 64'(sb_dmem),
                64'(tbl[i].dreq));
            chk($sformatf("tbl%0d_cnt", i), 64'(sb_cnt), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_ph_a", i), 64'(sa_phase),
                64'(tbl[i].ph));
        end

        // Data access acked on its fifth cycle.
        do_reset();
        imem_ack = 1; cyc();
        imem_ack = 0; cyc();
        cyc();
        mem_op = 1; cyc();
        mem_op = 0;
        n8 = 0; nd = 0;
        for (int k = 1; k <= 5; k++) begin
            dmem_ack = (k == 5);
            cyc();
            n8 += (sb_phase == 5'd8) ? 1 : 0;
            nd += sb_dmem ? 1 : 0;
        end
        dmem_ack = 0;
        cyc();
        chk("m_hold_cycles", 64'(n8), 64'd5);
        chk("dmem_req_cycles", 64'(nd), 64'd5);
        chk("after_m_phase", 64'(sb_phase), 64'd16);
        chk("a_dmem_timeout", 64'(sa_fault), 64'd1);

        // Fetch timeout on A, then ack on the last allowed cycle.
        do_reset();
        ni = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            ni += sa_imem ? 1 : 0;
        end
        chk("timeout_req_cycles", 64'(ni), 64'd4);
        chk("timeout_fault", 64'(sa_fault), 64'd1);
        chk("timeout_phase", 64'(sa_phase), 64'd0);
        chk("b_still_fetching", 64'(sb_imem), 64'd1);
        do_reset();
        cyc(); cyc(); cyc();
        imem_ack = 1; cyc();
        imem_ack = 0; cyc();
        chk("last_ack_phase", 64'(sa_phase), 64'd1);
        chk("last_ack_nofault", 64'(sa_fault), 64'd0);

        // Halt, ignored acks, run pulse.
        do_reset();
        run_instr(0, 1);
        cyc();
        chk("halted", 64'(sb_halt), 64'd1);
        chk("halt_phase", 64'(sb_phase), 64'd0);
        for (int k = 0; k < 4; k++) begin
            imem_ack = 1'($urandom);
            dmem_ack = 1'($urandom);
            cyc();
        end
        clr_in();
        chk("halt_cnt_hold", 64'(sb_cnt), 64'd1);
        run = 1; cyc();
        run = 0; cyc();
        chk("wake_imem", 64'(sb_imem), 64'd1);
        chk("wake_unhalt", 64'(sb_halt), 64'd0);

        // Counter wrap on A, reset in the middle of a data access.
        do_reset();
        for (int k = 0; k < 17; k++) run_instr(0, 0);
        cyc();
        chk("wrap_a", 64'(sa_cnt), 64'd1);
        chk("count_b", 64'(sb_cnt), 64'd17);
        imem_ack = 1; cyc();
        imem_ack = 0; cyc();
        cyc();
        mem_op = 1; cyc();
        mem_op = 0; cyc();
        chk("m_dmem_req", 64'(sb_dmem), 64'd1);
        rst = 1; cyc();
        rst = 0;
        dmem_ack = 1; cyc();
        chk("rst_outs_b", 64'({sb_phase, sb_imem, sb_dmem, sb_halt,
            sb_fault, sb_cnt}), 64'({5'd0, 4'b1000, 32'd0}));
        chk("rst_outs_a", 64'({sa_phase, sa_imem, sa_dmem, sa_halt,
            sa_fault, sa_cnt}), 64'({5'd0, 4'b1000, 4'd0}));
        dmem_ack = 0; cyc();
        chk("late_ack_ignored", 64'(sb_imem), 64'd1);

`ifdef PHASE_GEN_STEP_EN
        // Single stepping.
        do_reset();
        step_mode = 1;
        run_instr(0, 0);
        cyc();
        chk("step_halt", 64'(sb_halt), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step = 1; cyc();
            step = 0;
            run_instr(0, 0);
            cyc();
            chk($sformatf("step%0d_halt", k), 64'(sb_halt), 64'd1);
        end
        chk("step_count", 64'(sb_cnt), 64'd4);
        step_mode = 0;
`endif

        // Random stimulus against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(99) == 0);
            imem_ack = ($urandom_range(9) < 7);
            dmem_ack = ($urandom_range(9) < 7);
            mem_op   = 1'($urandom);
            halt_in  = ($urandom_range(7) == 0);
            run      = ($urandom_range(3) == 0);
`ifdef PHASE_GEN_STEP_EN
            step      = ($urandom_range(3) == 0);
            step_mode = ($urandom_range(9) == 0);
`endif
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phase_gen.md
PHASE_GEN -- requirements
Module: phase_gen

Interface
REQ-001 Parameter: TIMEOUT, 255, max wait cycles on a memory handshake before fault; 0 disables the timeout.
REQ-002 Parameter: CNT_W, 32, width of the retired-instruction counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 phase  out  5  one-hot phase vector; bit 0=f, 1=r, 2=x, 3=m, 4=w.
REQ-006 imem_req  out  1  instruction-fetch request; imem_ack  in  1  fetch done.
REQ-007 dmem_req  out  1  data-access request; dmem_ack  in  1  data access done.
REQ-008 mem_op  in  1  current instruction needs a data access; valid during phase x.
REQ-009 halt_in  in  1  current instruction is a halt; valid during phase w.
REQ-010 run  in  1  leave HALT.
REQ-011 halted  out  1; fault  out  1; instr_count  out  CNT_W  retired instructions.

Function
REQ-012 The FSM SHALL have states FWAIT, F, R, X, M, W, HALT and FAULT.
REQ-013 Phase bits: F->bit0, R->bit1, X->bit2, M->bit3, W->bit4; FWAIT, HALT and FAULT drive phase=5'b00000.
REQ-014 phase[0] SHALL never be high for two consecutive cycles, because the consumer advances pc by 4 on every cycle with phase[0]=1.
REQ-015 FWAIT: imem_req=1; go to F on the first cycle with imem_ack=1.
REQ-016 F->R->X are unconditional single-cycle steps.
REQ-017 mem_op is latched at the end of X into mem_op_q.
REQ-018 X->M is unconditional.
REQ-019 M: dmem_req=mem_op_q; leave for W when mem_op_q=0 (M lasts one cycle) or when dmem_ack=1.
REQ-020 W: go to HALT if halt_in=1, else to FWAIT.
REQ-021 instr_count SHALL increment by 1 on every W cycle and wrap modulo 2^CNT_W.
REQ-022 HALT: halted=1; go to FWAIT on run=1.
REQ-023 run in any other state SHALL be ignored.
REQ-024 An ack arriving with no request asserted SHALL be ignored.
REQ-025 An ack in the same cycle as its request SHALL complete the access.
REQ-026 Wait counter: cleared on entry to FWAIT or M, and incremented each waiting cycle without ack.
REQ-027 If TIMEOUT>0 and the counter equals TIMEOUT-1 with no ack, the next state SHALL be FAULT, so there are at most TIMEOUT request cycles.
REQ-028 An ack on the final allowed cycle SHALL win over the timeout.
REQ-029 FAULT: fault=1 and all requests low; it is left only by rst.
REQ-030 All outputs SHALL be registered or decoded from state only; there is no combinational path from any input to any output.

Reset
REQ-031 rst=1 SHALL take priority over every other input in the same cycle.
REQ-032 Reset values: state=FWAIT, phase=0, imem_req=1 from the first post-reset cycle, dmem_req=0, halted=0, fault=0, instr_count=0, mem_op_q=0, wait counter=0.
REQ-033 rst asserted mid-handshake SHALL abandon the access; a late ack SHALL NOT affect the new FWAIT.

Configuration
REQ-034 Macro PHASE_GEN_STEP_EN SHALL be the only compile-time option.
REQ-035 When defined, inputs step_mode and step (1 bit each) SHALL exist.
REQ-036 With step_mode=1, W SHALL go to HALT regardless of halt_in.
REQ-037 In HALT, step=1 OR run=1 SHALL go to FWAIT.
REQ-038 When undefined, the step_mode and step ports are absent and behaviour is as in REQ-020 and REQ-022.

Structure
REQ-039 Shared package phase_pkg SHALL hold the phase index constants (F_IDX=0..W_IDX=4), PHASE_W=5 and the state enum type.
REQ-040 The timeout counter SHALL be sub-module wait_timer (inputs clear, tick, done; output expired), instantiated once and shared by FWAIT and M.

Verification
REQ-041 After reset, imem_ack=1 on the 3rd cycle and mem_op=0 -> phase sequence 0,0,0,1,2,4,8,16, then imem_req=1 again; instr_count=1.
REQ-042 mem_op=1, dmem_ack after 4 cycles -> phase=8 held for 5 cycles; dmem_req high exactly those 5 cycles; then phase=16.
REQ-043 TIMEOUT=4, imem_ack never asserted -> imem_req high for 4 cycles, then fault=1 and phase=0 until rst; ack on the 4th cycle -> F, no fault.
REQ-044 halt_in=1 in W -> halted=1 and phase=0; run pulse -> FWAIT next cycle; instr_count unchanged during HALT.
REQ-045 With PHASE_GEN_STEP_EN and step_mode=1 -> HALT after each W; 3 step pulses retire exactly 3 instructions; phase[0] is never high on consecutive cycles.
REQ-046 CNT_W=4, 17 instructions retired -> instr_count=1 (wrap); rst during M with dmem_req=1 -> all outputs at reset values next cycle.
